// File: rtl/timer_alarm_pkg.sv
// rtl/timer_alarm_pkg.sv - shared states, timer register map and bus-cycle helper
package timer_alarm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL_ON,
    S_RUN,
    S_ACK,
    S_WR_CTRL_OFF
  } state_e;

  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [2:0]  ADDR_PERIODL = 3'd2;
  localparam logic [2:0]  ADDR_PERIODH = 3'd3;
  localparam logic [15:0] CTRL_ITO     = 16'h0001;

  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } tmr_bus_t;

  localparam tmr_bus_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};

  // Bus cycle presented while the FSM sits in state s; non-write states park the bus.
  function automatic tmr_bus_t bus_for(input state_e s, input logic [31:0] period);
    tmr_bus_t b;
    b = BUS_IDLE;
    case (s)
      S_WR_PL:       b = '{cs: 1'b1, wr_n: 1'b0, addr: ADDR_PERIODL, data: period[15:0]};
      S_WR_PH:       b = '{cs: 1'b1, wr_n: 1'b0, addr: ADDR_PERIODH, data: period[31:16]};
      S_WR_CTRL_ON:  b = '{cs: 1'b1, wr_n: 1'b0, addr: ADDR_CONTROL, data: CTRL_ITO};
      S_ACK:         b = '{cs: 1'b1, wr_n: 1'b0, addr: ADDR_STATUS,  data: 16'h0000};
      S_WR_CTRL_OFF: b = '{cs: 1'b1, wr_n: 1'b0, addr: ADDR_CONTROL, data: 16'h0000};
      default:       b = BUS_IDLE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer_alarm_sequencer.sv
// rtl/timer_alarm_sequencer.sv - Avalon-MM master that programs the interval timer and counts its timeouts into alarms
module timer_alarm_sequencer
  import timer_alarm_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_period,
  input  logic [TICK_W-1:0] cfg_ticks,
  input  logic              cfg_repeat,
  input  logic              stop,
  output logic              busy,
  output logic              alarm,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq
);

  state_e            r_state;
  state_e            w_next_state;
  logic [31:0]       r_period;
  logic [31:0]       w_period_next;
  logic [TICK_W-1:0] r_target;
  logic [TICK_W-1:0] r_tick_count;
  logic [TICK_W-1:0] w_tick_inc;
  logic [TICK_W-1:0] w_tick_next;
  logic              r_repeat;
  logic              w_accept;
  logic              w_hit;
  tmr_bus_t          r_bus;

  assign w_accept      = (r_state == S_IDLE) && cfg_valid;
  assign w_period_next = w_accept ? cfg_period : r_period;
  assign w_tick_inc    = r_tick_count + {{(TICK_W-1){1'b0}}, 1'b1};
  assign w_hit         = (w_tick_inc == r_target);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:        if (cfg_valid) w_next_state = S_WR_PL;
      S_WR_PL:       w_next_state = stop ? S_WR_CTRL_OFF : S_WR_PH;
      S_WR_PH:       w_next_state = stop ? S_WR_CTRL_OFF : S_WR_CTRL_ON;
      S_WR_CTRL_ON:  w_next_state = stop ? S_WR_CTRL_OFF : S_RUN;
      S_RUN: begin
        if (stop)         w_next_state = S_WR_CTRL_OFF;
        else if (tmr_irq) w_next_state = S_ACK;
      end
      S_ACK:         w_next_state = (stop || (w_hit && !r_repeat)) ? S_WR_CTRL_OFF : S_RUN;
      S_WR_CTRL_OFF: w_next_state = S_IDLE;
      default:       w_next_state = S_IDLE;
    endcase
  end

  // An aborted ACK still counts, but never clears the count as a match would.
  always_comb begin
    w_tick_next = r_tick_count;
    if (w_accept)
      w_tick_next = '0;
    else if (r_state == S_ACK)
      w_tick_next = (w_hit && r_repeat && !stop) ? '0 : w_tick_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_period     <= '0;
      r_target     <= '0;
      r_repeat     <= 1'b0;
      r_tick_count <= '0;
      r_bus        <= BUS_IDLE;
    end else begin
      r_state      <= w_next_state;
      r_period     <= w_period_next;
      r_tick_count <= w_tick_next;
      r_bus        <= bus_for(w_next_state, w_period_next);
      if (w_accept) begin
        r_target <= (cfg_ticks == '0) ? {{(TICK_W-1){1'b0}}, 1'b1} : cfg_ticks;
        r_repeat <= cfg_repeat;
      end
    end
  end

  assign cfg_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign alarm          = (r_state == S_ACK) && w_hit && !stop;
  assign tick_count     = r_tick_count;
  assign tmr_chipselect = r_bus.cs;
  assign tmr_write_n    = r_bus.wr_n;
  assign tmr_address    = r_bus.addr;
  assign tmr_writedata  = r_bus.data;

endmodule

// File: tb/tb_timer_alarm_sequencer.sv
// tb/tb_timer_alarm_sequencer.sv - self-checking bench with an interval-timer model and transaction-level expectations
module tb_timer_alarm_sequencer;

  localparam int TICK_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [31:0]       cfg_period = '0;
  logic [TICK_W-1:0] cfg_ticks = '0;
  logic              cfg_repeat = 1'b0;
  logic              stop = 1'b0;
  logic              busy;
  logic              alarm;
  logic [TICK_W-1:0] tick_count;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq;
  logic              force_irq = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_alarm_sequencer #(.TICK_W(TICK_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_ticks(cfg_ticks), .cfg_repeat(cfg_repeat),
    .stop(stop), .busy(busy), .alarm(alarm), .tick_count(tick_count),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
  );

  // Interval timer: reload the cycle after a PERIODH write, timeout every period+1 cycles,
  // a status write clears timeout (winning over a coincident timeout), control bit0 = ITO.
  logic [31:0] m_period, m_cnt;
  logic        m_run, m_reload, m_to, m_ito;
  assign tmr_irq = (m_to && m_ito) || force_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_period <= '0; m_cnt <= '0; m_run <= 1'b0; m_reload <= 1'b0; m_to <= 1'b0; m_ito <= 1'b0;
    end else begin
      m_reload <= 1'b0;
      if (m_reload) begin
        m_cnt <= m_period; m_run <= 1'b1;
      end else if (m_run) begin
        if (m_cnt == 0) begin m_cnt <= m_period; m_to <= 1'b1; end
        else m_cnt <= m_cnt - 1;
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin m_ito <= tmr_writedata[0]; if (!tmr_writedata[0]) m_run <= 1'b0; end
          3'd2: m_period[15:0] <= tmr_writedata;
          3'd3: begin m_period[31:16] <= tmr_writedata; m_reload <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { int cyc; logic [2:0] addr; logic [15:0] data; } wr_t;
  wr_t wr_q[$];
  int  alarm_q[$];
  int  tick_q[$];
  int  idle_cyc = -1;
  logic prev_busy = 1'b0;
  logic [TICK_W-1:0] prev_tick = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (tmr_chipselect) begin
        wr_q.push_back('{cyc, tmr_address, tmr_writedata});
        chk("write_n_low", {31'b0, tmr_write_n}, 32'd0);
      end else begin
        chk("bus_parked", {12'b0, tmr_write_n, tmr_address, tmr_writedata}, {12'b0, 1'b1, 3'b0, 16'b0});
      end
      chk("ready_not_busy", {31'b0, cfg_ready}, {31'b0, !busy});
      if (alarm) begin
        alarm_q.push_back(cyc);
        chk("alarm_in_ack", {28'b0, tmr_chipselect, tmr_address}, {28'b0, 1'b1, 3'd0});
      end
      if (busy && prev_busy && tick_count != prev_tick) tick_q.push_back(int'(tick_count));
      if (!busy && prev_busy) idle_cyc = cyc;
    end
    prev_busy <= busy;
    prev_tick <= tick_count;
  end

  task automatic clear_logs();
    wr_q.delete(); alarm_q.delete(); tick_q.delete(); idle_cyc = -1;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_cs"},    {31'b0, tmr_chipselect}, 32'd0);
    chk({tag, "_wr_n"},  {31'b0, tmr_write_n}, 32'd1);
    chk({tag, "_addr"},  {29'b0, tmr_address}, 32'd0);
    chk({tag, "_data"},  {16'b0, tmr_writedata}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'b0, cfg_ready}, 32'd1);
    chk({tag, "_alarm"}, {31'b0, alarm}, 32'd0);
    chk({tag, "_ticks"}, {16'b0, tick_count}, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy && g < 400) begin @(posedge clk); #1; g++; end
    stop = 1'b0;
    chk({tag, "_idle_reached"}, {31'b0, busy}, 32'd0);
    @(negedge clk); #1;
  endtask

  // Offer a config, wait for n_al alarms, stop if the run would not end on its own.
  task automatic run_cfg(input string tag, input logic [31:0] p, input logic [15:0] t, input logic r,
                         input int n_al, output int acc);
    int g = 0;
    int tgt;
    tgt = (t == 0) ? 1 : int'(t);
    clear_logs();
    while (!cfg_ready && g < 50) begin @(posedge clk); #1; g++; end
    cfg_period = p; cfg_ticks = t; cfg_repeat = r; cfg_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc; cfg_valid = 1'b0;
    if (n_al == 0) begin
      repeat (6) @(posedge clk);
      #1 stop = 1'b1;
    end else begin
      g = 0;
      while (alarm_q.size() < n_al && g < (int'(p) + 1) * tgt * n_al + 40) begin @(posedge clk); #1; g++; end
      chk({tag, "_alarms_seen"}, alarm_q.size(), n_al);
      if (r) stop = 1'b1;
    end
    wait_idle(tag);
  endtask

  // Expected transaction list derived from the operating rules, then compared against the log.
  task automatic check_run(input string tag, input logic [31:0] p, input logic [15:0] t, input logic r,
                           input int n_al, input int acc);
    wr_t exp[$];
    int  exp_tick[$];
    int  tgt, n_ack, cur, prv;
    tgt   = (t == 0) ? 1 : int'(t);
    n_ack = n_al * tgt;
    exp.push_back('{0, 3'd2, p[15:0]});
    exp.push_back('{0, 3'd3, p[31:16]});
    exp.push_back('{0, 3'd1, 16'h0001});
    for (int i = 0; i < n_ack; i++) exp.push_back('{0, 3'd0, 16'h0000});
    exp.push_back('{0, 3'd1, 16'h0000});
    chk({tag, "_n_writes"}, wr_q.size(), exp.size());
    chk({tag, "_n_alarms"}, alarm_q.size(), n_al);
    if (wr_q.size() == exp.size()) begin
      for (int i = 0; i < exp.size(); i++)
        chk($sformatf("%s_write%0d", tag, i), {13'b0, wr_q[i].addr, wr_q[i].data}, {13'b0, exp[i].addr, exp[i].data});
      for (int i = 0; i < 3; i++) chk({tag, "_cfg_cycle"}, wr_q[i].cyc, acc + i);
      for (int i = 3; i < 2 + n_ack; i++) chk({tag, "_ack_gap"}, wr_q[i+1].cyc - wr_q[i].cyc, p + 1);
      chk({tag, "_ready_after_off"}, idle_cyc, wr_q[exp.size()-1].cyc + 1);
      if (alarm_q.size() == n_al)
        for (int k = 0; k < n_al; k++) chk({tag, "_alarm_cycle"}, alarm_q[k], wr_q[3 + (k+1)*tgt - 1].cyc);
    end
    cur = 0; prv = 0;
    for (int i = 0; i < n_ack; i++) begin
      cur = cur + 1;
      if (cur == tgt && r) cur = 0;
      if (cur != prv) exp_tick.push_back(cur);
      prv = cur;
    end
    chk({tag, "_n_tick_changes"}, tick_q.size(), exp_tick.size());
    if (tick_q.size() == exp_tick.size())
      for (int i = 0; i < exp_tick.size(); i++) chk({tag, "_tick_seq"}, tick_q[i], exp_tick[i]);
  endtask

  typedef struct {
    logic [31:0] period; logic [15:0] ticks; logic rpt; int n_al;
    logic [15:0] exp_pl; logic [15:0] exp_ph; int exp_acks; int exp_ack_gap; int exp_alarm_gap;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int acc, n_acks, first_ack;
    logic [31:0] rp; logic [15:0] rt; logic rr; int rn;

    vecs[0] = '{32'h0001_86A0, 16'd3, 1'b0, 0, 16'h86A0, 16'h0001, 0, 0, 0};
    vecs[1] = '{32'd9,         16'd3, 1'b0, 1, 16'h0009, 16'h0000, 3, 10, 0};
    vecs[2] = '{32'd9,         16'd0, 1'b0, 1, 16'h0009, 16'h0000, 1, 0, 0};
    vecs[3] = '{32'd4,         16'd1, 1'b0, 1, 16'h0004, 16'h0000, 1, 0, 0};
    vecs[4] = '{32'd9,         16'd2, 1'b1, 2, 16'h0009, 16'h0000, 4, 10, 20};
    vecs[5] = '{32'd5,         16'd2, 1'b0, 1, 16'h0005, 16'h0000, 2, 6, 0};
    vecs[6] = '{32'hABCD_1234, 16'd1, 1'b1, 0, 16'h1234, 16'hABCD, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1 reset_vals("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_cfg($sformatf("vec%0d", i), vecs[i].period, vecs[i].ticks, vecs[i].rpt, vecs[i].n_al, acc);
      check_run($sformatf("vec%0d", i), vecs[i].period, vecs[i].ticks, vecs[i].rpt, vecs[i].n_al, acc);
      if (wr_q.size() >= 2) begin
        chk("vec_pl_data", wr_q[0].data, vecs[i].exp_pl);
        chk("vec_ph_data", wr_q[1].data, vecs[i].exp_ph);
      end
      n_acks = 0; first_ack = -1;
      foreach (wr_q[j]) if (wr_q[j].addr == 3'd0) begin
        if (n_acks == 1) chk("vec_ack_gap", wr_q[j].cyc - first_ack, vecs[i].exp_ack_gap);
        if (n_acks == 0) first_ack = wr_q[j].cyc;
        n_acks++;
      end
      chk("vec_ack_count", n_acks, vecs[i].exp_acks);
      if (vecs[i].exp_alarm_gap != 0 && alarm_q.size() >= 2)
        chk("vec_alarm_gap", alarm_q[1] - alarm_q[0], vecs[i].exp_alarm_gap);
    end

    clear_logs();
    cfg_period = 32'd9; cfg_ticks = 16'd1; cfg_repeat = 1'b0; cfg_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc; cfg_valid = 1'b0;
    @(posedge clk); #1;
    stop = 1'b1;
    wait_idle("stop_ph");
    chk("stop_ph_n_writes", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      chk("stop_ph_w0", {wr_q[0].addr, wr_q[0].data}, {3'd2, 16'h0009});
      chk("stop_ph_w1", {wr_q[1].addr, wr_q[1].data}, {3'd3, 16'h0000});
      chk("stop_ph_w2", {wr_q[2].addr, wr_q[2].data}, {3'd1, 16'h0000});
      chk("stop_ph_off_cycle", wr_q[2].cyc, acc + 2);
      chk("stop_ph_idle_cycle", idle_cyc, acc + 3);
    end
    chk("stop_ph_no_alarm", alarm_q.size(), 0);

    clear_logs();
    stop = 1'b1;
    repeat (5) @(posedge clk);
    #1 stop = 1'b0;
    chk("stop_idle_no_writes", wr_q.size(), 0);
    chk("stop_idle_busy", {31'b0, busy}, 32'd0);

    clear_logs();
    force_irq = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_idle_no_writes", wr_q.size(), 0);
    chk("irq_idle_ready", {31'b0, cfg_ready}, 32'd1);
    force_irq = 1'b0;

    clear_logs();
    cfg_period = 32'd9; cfg_ticks = 16'd1; cfg_repeat = 1'b0; cfg_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    cfg_period = 32'd7; cfg_ticks = 16'd2; cfg_repeat = 1'b1;
    repeat (8) @(posedge clk);
    #1 cfg_valid = 1'b0;
    wait_idle("valid_busy");
    check_run("valid_busy", 32'd9, 16'd1, 1'b0, 1, acc);

    clear_logs();
    cfg_period = 32'd9; cfg_ticks = 16'd5; cfg_repeat = 1'b1; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 reset_vals("reset_mid_run");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    clear_logs();
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_no_writes", wr_q.size(), 0);
    reset_vals("post_reset");

    for (int it = 0; it < 8; it++) begin
      rp = 32'($urandom_range(4, 14));
      rt = 16'($urandom_range(0, 4));
      rr = 1'($urandom_range(0, 1));
      rn = rr ? int'($urandom_range(1, 3)) : 1;
      run_cfg($sformatf("rand%0d", it), rp, rt, rr, rn, acc);
      check_run($sformatf("rand%0d", it), rp, rt, rr, rn, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_alarm_sequencer.md
# timer_alarm_sequencer

Avalon-MM master controller that programs and services the interval timer's s1 slave. It sequences the period and control writes and acknowledges each timeout by clearing the timer status. It counts timeouts and raises a one-cycle alarm after a programmed number of ticks, in one-shot or repeating mode. It sits between the system CPU/host logic and the timer, so software never touches the timer registers directly.

## Interface
- TICK_W, 16, width of tick target and tick counter
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  host offers a new alarm configuration
- cfg_ready  out  1  high only in IDLE; accept when cfg_valid && cfg_ready
- cfg_period  in  32  timer load value; timer period = cfg_period+1 cycles; must be >= 4
- cfg_ticks  in  TICK_W  timeouts per alarm; 0 treated as 1
- cfg_repeat  in  1  1 = periodic alarm, 0 = one-shot
- stop  in  1  level; abort running alarm
- busy  out  1  high in every state except IDLE
- alarm  out  1  one-cycle pulse when tick target reached
- tick_count  out  TICK_W  timeouts acknowledged since last (re)arm
- tmr_address  out  3  timer s1 address
- tmr_chipselect  out  1  timer s1 chipselect
- tmr_write_n  out  1  timer s1 write strobe, active-low
- tmr_writedata  out  16  timer s1 write data
- tmr_irq  in  1  timer interrupt (timeout_occurred && ITO)

## Operation
- States: IDLE, WR_PL, WR_PH, WR_CTRL_ON, RUN, ACK, WR_CTRL_OFF.
- IDLE: cfg_ready=1. On accept, latch period, ticks (0→1) and repeat; clear tick_count; go to WR_PL.
- WR_PL: write address 2, data period[15:0]. WR_PH: write address 3, data period[31:16]. WR_CTRL_ON: write address 1, data 16'h0001. Then RUN.
- RUN: no bus activity. If tmr_irq=1, go to ACK.
- ACK: write address 0, data 0, which clears the timer status. Increment tick_count.
  - If the new count equals the target and repeat=1: pulse alarm, clear tick_count, return to RUN.
  - If the new count equals the target and repeat=0: pulse alarm, go to WR_CTRL_OFF.
  - Otherwise return to RUN.
- WR_CTRL_OFF: write address 1, data 0 (interrupt disabled). Go to IDLE.
- stop=1 in WR_PL, WR_PH, WR_CTRL_ON, RUN or ACK:
  - The current write completes; the next state is WR_CTRL_OFF.
  - An ACK in progress still counts, but does not pulse alarm.
- stop in IDLE or WR_CTRL_OFF: no effect.
- Bus rules:
  - Each write is exactly one cycle with tmr_chipselect=1 and tmr_write_n=0; the timer has no waitrequest.
  - Outside write states: chipselect=0, write_n=1, address=0, writedata=0.
  - All tmr_* outputs are registered.
- Arithmetic: tick_count wraps modulo 2^TICK_W. It cannot exceed the target because it is cleared on match.

## Timing
- Reset values: state=IDLE, cfg_ready=1, busy=0, alarm=0, tick_count=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. Latched config = 0.
- Reset mid-operation: return immediately to IDLE with no further writes. The timer shares reset_n and resets itself.
- Accept to first timer write (WR_PL): 1 cycle. Accept to RUN: 4 cycles.
- The timer force-reloads on the cycle after the PH write, so the first period starts from the new value.
- tmr_irq high in RUN → ACK write on the next cycle. The timer clears the status on that edge, so irq is low when RUN resumes.
- alarm is high during the ACK cycle that completes the target.
- Minimum period of 4 cycles keeps the ACK clear from colliding with the next timeout event. If they collide, the timer's clear wins and that tick is lost.
- A cfg_valid held during busy is ignored until IDLE.

## Structure
- Shared package timer_alarm_pkg:
  - state enum;
  - timer register address constants ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIODL=2, ADDR_PERIODH=3;
  - CTRL_ITO=16'h0001.
- No sub-module is needed; the FSM, config latch and tick counter live in one module.

## Test plan
- Reset: assert reset_n=0 mid-RUN → all outputs at reset values, no chipselect, cfg_ready=1.
- Config sequence: accept period=32'h0001_86A0, ticks=3, repeat=0 → writes (2,16'h86A0), (3,16'h0001), (1,16'h0001) on consecutive cycles. Then busy with the bus idle.
- One-shot alarm: with the real timer, period=9, ticks=3 →
  - three ACK writes (0,0), 10 cycles apart;
  - alarm is one cycle, in the third ACK;
  - then write (1,0); cfg_ready returns next cycle.
- Repeat mode: period=9, ticks=2, repeat=1 → alarm every 20 cycles. tick_count sequence 1,0,1,0; the block never leaves RUN/ACK.
- Stop: assert stop during WR_PH → PH write completes, next cycle write (1,0), then IDLE, no alarm. Stop in IDLE → no bus activity.
- Boundaries:
  - ticks=0 → alarm on the first timeout;
  - cfg_valid during busy → not accepted;
  - tmr_irq forced high while in IDLE → ignored.
